nios_system_com_rx_writer: RTL and testbench
============================================

// Module: nios_system_com_rx_writer
// PURPOSE
// Upstream feeder for the communication on-chip memory (256x32 single-port RAM, Avalon slave).
// Accepts a byte stream of received Car2X frames (sop/eop framed, valid/ready) and packs bytes
// little-endian into 32-bit words.
// Writes each frame into a ring region of that memory as a header word plus data words.
// Publishes a committed write pointer and an IRQ pulse so the Nios CPU can consume frames.
// PARAMETERS
// BASE_ADDR  128  first word address of the ring region inside the memory
// DEPTH      128  ring size in words; power of two; BASE_ADDR+DEPTH <= 256
// MAX_WORDS  16   max data words stored per frame; longer frames are truncated
// PTR_W      7    log2(DEPTH); ring offset width
// PORTS
// clk             in   1   system clock
// reset_n         in   1   asynchronous active-low reset
// enable          in   1   1 = accept new frames (sampled only at sop in IDLE)
// rx_data         in   8   stream byte
// rx_valid        in   1   rx_data valid
// rx_sop          in   1   first byte of frame (qualified by rx_valid)
// rx_eop          in   1   last byte of frame (qualified by rx_valid)
// rx_ready        out  1   byte accepted when rx_valid & rx_ready
// sw_rd_ptr       in   PTR_W  CPU read offset (next header word software will read)
// wr_ptr          out  PTR_W  committed write offset (one past last committed frame)
// irq             out  1   one-cycle pulse per committed frame
// drop_count      out  8   frames rejected for lack of space; saturates at 255
// mem_address     out  8   memory address = BASE_ADDR + offset
// mem_byteenable  out  4   byte lanes of mem_writedata
// mem_chipselect  out  1   memory select; equals mem_write
// mem_write       out  1   one-cycle write strobe
// mem_writedata   out  32  write word
// mem_clken       out  1   tied 1
// BEHAVIOUR
// Reset: all outputs 0 except mem_clken=1; state IDLE, seq=0, wr_ptr=0, pack buffer cleared.
// Reset mid-frame: the partial frame is abandoned; data already written is not committed.
// Ring: offsets wrap DEPTH-1 -> 0; used=(wr_ptr-sw_rd_ptr) mod DEPTH; free=DEPTH-1-used.
// Frame layout: header at offset h, data words at h+1.. (wrapping).
// Header = {len[15:0] bytes stored, seq[7:0], flags[7:0]}; flags[0]=TRUNC, others 0.
// States:
//  IDLE: rx_ready=1.
//   - Valid byte without sop: discarded.
//   - Valid sop byte: if enable=1 and free >= MAX_WORDS+1, then h=wr_ptr, cur=wr_ptr+1,
//     byte packed in lane 0 -> DATA (or FLUSH if eop too).
//   - Else drop_count++ -> DROP (or stay IDLE if eop).
//  DATA: rx_ready=1; byte k goes to lane k mod 4; sop ignored.
//   - Byte completing a word: write issued next cycle (be=1111), cur++.
//   - After MAX_WORDS words: further bytes discarded, TRUNC set, len frozen.
//   - eop -> FLUSH.
//  FLUSH: rx_ready=0.
//   - Pending partial word written with be = lanes filled (e.g. 1 byte -> 0001), unused lanes 0.
//   - No write if none pending.
//   - -> HDR.
//  HDR: rx_ready=0; header written at offset h, be=1111 -> COMMIT.
//  COMMIT: wr_ptr<=cur, irq=1, seq++ (255 wraps to 0) -> IDLE; rx_ready=0 this cycle.
//  DROP: rx_ready=1; bytes discarded until eop -> IDLE.
// Timing: a byte accepted at cycle t appears on mem_* at t+1 (one registered stage).
//   eop at t -> data flush t+1, header t+2, wr_ptr/irq t+3; next byte accepted at t+4 earliest.
// Write port: at most one write per cycle; mem_write never asserted outside these cases.
// enable falling mid-frame: the current frame completes normally.
// sw_rd_ptr changing mid-frame: free space is only checked at sop.
// TESTING
// 1. BASE=128, rd=wr=0; frame 01 02 03 04 05 (sop on 01, eop on 05)
//    -> wr 129=0x04030201 be 1111; wr 130=0x00000005 be 0001; wr 128=0x00050000; wr_ptr=3; irq 1 cycle.
// 2. Frame of 4 bytes AA BB CC DD
//    -> single data write 0xDDCCBBAA be 1111; no FLUSH write; header len=4; seq increments to 1.
// 3. MAX_WORDS=16; 70-byte frame
//    -> 16 data writes; bytes 65..70 discarded; header len=64, flags=0x01; wr_ptr advances 17.
// 4. sw_rd_ptr=wr_ptr+10 (free=9); sop
//    -> frame dropped, no mem_write, drop_count=1, rx_ready stays 1 until eop; wr_ptr unchanged.
// 5. wr_ptr=126, 3-word frame
//    -> header at 254, data at 255,128,129; wr_ptr=2 (wrap).
// 6. reset_n low after 6 bytes of a frame
//    -> outputs cleared immediately; after release wr_ptr=0, next frame header at 128.

Source files
------------

// File: rtl/nios_system_com_rx_writer.sv
// Packs a sop/eop framed byte stream into 32-bit words and writes each frame into a ring
// region of the communication memory as header + data, then publishes wr_ptr and an irq.
module nios_system_com_rx_writer #(
   parameter int unsigned BASE_ADDR = 128,
   parameter int unsigned DEPTH     = 128,
   parameter int unsigned MAX_WORDS = 16,
   parameter int unsigned PTR_W     = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_sop,
   input  logic             rx_eop,
   output logic             rx_ready,
   input  logic [PTR_W-1:0] sw_rd_ptr,
   output logic [PTR_W-1:0] wr_ptr,
   output logic             irq,
   output logic [7:0]       drop_count,
   output logic [7:0]       mem_address,
   output logic [3:0]       mem_byteenable,
   output logic             mem_chipselect,
   output logic             mem_write,
   output logic [31:0]      mem_writedata,
   output logic             mem_clken
);

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned LEN_W    = 16;
   localparam int unsigned WCNT_W   = $clog2(MAX_WORDS + 1);
   localparam int unsigned MIN_FREE = MAX_WORDS + 1;

   typedef enum logic [2:0] {S_IDLE, S_DATA, S_FLUSH, S_HDR, S_COMMIT, S_DROP} state_e;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [7:0]       seq;
      logic [7:0]       flags;
   } hdr_t;

   state_e              state_q, state_d;
   logic [7:0]          seq_q, seq_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    hdr_q, hdr_d;
   logic [PTR_W-1:0]    cur_q, cur_d;
   logic [DATA_W-1:0]   pack_q, pack_d;
   logic [1:0]          lanes_q, lanes_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                trunc_q, trunc_d;
   logic [WCNT_W-1:0]   words_q, words_d;
   logic [7:0]          drop_q, drop_d;
   logic                irq_q, irq_d;
   logic                ready_q, ready_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          be_q, be_d;
   logic [DATA_W-1:0]   wd_q, wd_d;

   logic                accept_c;
   logic [PTR_W-1:0]    used_c;
   logic [PTR_W-1:0]    free_c;
   logic                space_ok_c;
   logic [DATA_W-1:0]   word_c;
   hdr_t                hdr_w;

   function automatic logic [ADDR_W-1:0] mem_addr(input logic [PTR_W-1:0] off);
      return ADDR_W'(BASE_ADDR + 32'(off));
   endfunction

   function automatic logic [3:0] lanes_be(input logic [1:0] last_lane);
      logic [3:0] be;
      case (last_lane)
         2'd0:    be = 4'b0001;
         2'd1:    be = 4'b0011;
         2'd2:    be = 4'b0111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   assign accept_c   = rx_valid & ready_q;
   assign used_c     = PTR_W'(wr_ptr_q - sw_rd_ptr);
   assign free_c     = PTR_W'(DEPTH - 1) - used_c;
   assign space_ok_c = 32'(free_c) >= MIN_FREE;

   // Current pack word with the incoming byte dropped into its lane
   always_comb begin
      word_c = pack_q;
      word_c[{lanes_q, 3'b000} +: 8] = rx_data;
   end

   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      wr_ptr_d = wr_ptr_q;
      hdr_d    = hdr_q;
      cur_d    = cur_q;
      pack_d   = pack_q;
      lanes_d  = lanes_q;
      len_d    = len_q;
      trunc_d  = trunc_q;
      words_d  = words_q;
      drop_d   = drop_q;
      irq_d    = 1'b0;
      we_d     = 1'b0;
      addr_d   = '0;
      be_d     = '0;
      wd_d     = '0;
      hdr_w    = '{len: len_q, seq: seq_q, flags: {7'b0, trunc_q}};

      case (state_q)
         S_IDLE: begin
            if (accept_c && rx_sop) begin
               if (enable && space_ok_c) begin
                  hdr_d   = wr_ptr_q;
                  len_d   = LEN_W'(1);
                  trunc_d = 1'b0;
                  words_d = '0;
                  if (rx_eop) begin
                     we_d    = 1'b1;
                     addr_d  = mem_addr(PTR_W'(wr_ptr_q + PTR_W'(1)));
                     be_d    = 4'b0001;
                     wd_d    = {24'b0, rx_data};
                     cur_d   = PTR_W'(wr_ptr_q + PTR_W'(2));
                     pack_d  = '0;
                     lanes_d = '0;
                     state_d = S_FLUSH;
                  end else begin
                     cur_d   = PTR_W'(wr_ptr_q + PTR_W'(1));
                     pack_d  = {24'b0, rx_data};
                     lanes_d = 2'd1;
                     state_d = S_DATA;
                  end
               end else begin
                  drop_d = (drop_q == 8'hFF) ? drop_q : 8'(drop_q + 8'd1);
                  if (!rx_eop) state_d = S_DROP;
               end
            end
         end

         // A completed word or the eop byte leaves on the write port the next cycle
         S_DATA: begin
            if (accept_c) begin
               if (words_q == WCNT_W'(MAX_WORDS)) begin
                  trunc_d = 1'b1;
               end else begin
                  len_d = LEN_W'(len_q + LEN_W'(1));
                  if (lanes_q == 2'd3 || rx_eop) begin
                     we_d    = 1'b1;
                     addr_d  = mem_addr(cur_q);
                     be_d    = lanes_be(lanes_q);
                     wd_d    = word_c;
                     cur_d   = PTR_W'(cur_q + PTR_W'(1));
                     words_d = WCNT_W'(words_q + WCNT_W'(1));
                     pack_d  = '0;
                     lanes_d = '0;
                  end else begin
                     pack_d  = word_c;
                     lanes_d = 2'(lanes_q + 2'd1);
                  end
               end
               if (rx_eop) state_d = S_FLUSH;
            end
         end

         S_FLUSH: begin
            we_d    = 1'b1;
            addr_d  = mem_addr(hdr_q);
            be_d    = 4'b1111;
            wd_d    = hdr_w;
            state_d = S_HDR;
         end

         S_HDR: begin
            wr_ptr_d = cur_q;
            irq_d    = 1'b1;
            seq_d    = 8'(seq_q + 8'd1);
            state_d  = S_COMMIT;
         end

         S_COMMIT: state_d = S_IDLE;

         S_DROP: begin
            if (accept_c && rx_eop) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_DROP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         seq_q    <= '0;
         wr_ptr_q <= '0;
         hdr_q    <= '0;
         cur_q    <= '0;
         pack_q   <= '0;
         lanes_q  <= '0;
         len_q    <= '0;
         trunc_q  <= 1'b0;
         words_q  <= '0;
         drop_q   <= '0;
         irq_q    <= 1'b0;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         wr_ptr_q <= wr_ptr_d;
         hdr_q    <= hdr_d;
         cur_q    <= cur_d;
         pack_q   <= pack_d;
         lanes_q  <= lanes_d;
         len_q    <= len_d;
         trunc_q  <= trunc_d;
         words_q  <= words_d;
         drop_q   <= drop_d;
         irq_q    <= irq_d;
         ready_q  <= ready_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wd_q     <= wd_d;
      end
   end

   assign rx_ready       = ready_q;
   assign wr_ptr         = wr_ptr_q;
   assign irq            = irq_q;
   assign drop_count     = drop_q;
   assign mem_address    = addr_q;
   assign mem_byteenable = be_q;
   assign mem_chipselect = we_q;
   assign mem_write      = we_q;
   assign mem_writedata  = wd_q;
   assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_nios_system_com_rx_writer.sv
// Bench for nios_system_com_rx_writer: frame-level reference model of the ring writer,
// table of frame shapes, hand sequences for timing/wrap/drop/reset, then random frames.
module tb_nios_system_com_rx_writer;

   localparam int BASE  = 128;
   localparam int DEPTH = 128;
   localparam int MAXW  = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_sop = 1'b0;
   logic        rx_eop = 1'b0;
   logic        rx_ready;
   logic [6:0]  sw_rd_ptr = '0;
   logic [6:0]  wr_ptr;
   logic        irq;
   logic [7:0]  drop_count;
   logic [7:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;

   nios_system_com_rx_writer dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
      .rx_ready(rx_ready), .sw_rd_ptr(sw_rd_ptr), .wr_ptr(wr_ptr), .irq(irq),
      .drop_count(drop_count), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      int   n;
      logic en;
      int   off;
      int   adv;
      int   nwr;
   } vec_t;

   typedef logic [7:0] bytes_t[$];

   wr_t log_q[$];
   wr_t exp_q[$];
   int  cyc = 0;
   int  irq_cnt = 0;
   int  irq_cyc = 0;
   int  bad_side = 0;
   int  acc_cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  m_wr = 0;
   int  m_seq = 0;
   int  m_drop = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_write) log_q.push_back('{mem_address, mem_byteenable, mem_writedata, cyc});
      if (irq) begin
         irq_cnt++;
         irq_cyc = cyc;
      end
      if (mem_chipselect !== mem_write || mem_clken !== 1'b1) bad_side++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken
   task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
      int guard;
      guard = 0;
      rx_valid = 1'b1; rx_data = d; rx_sop = s; rx_eop = e;
      while (rx_ready !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got rx_ready=%b after %0d cycles expected 1", rx_ready, guard);
      end
      acc_cyc = cyc + 1;
      @(negedge clk);
      rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
   endtask

   function automatic bytes_t rand_bytes(input int n);
      bytes_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // Whole-frame expectation: stored bytes, word images, header, pointer and counters
   function automatic void model_frame(input bytes_t b, input logic en, input logic [6:0] rd);
      int used, free, stored, words, h;
      wr_t e;
      exp_q.delete();
      used = (m_wr - int'(rd) + DEPTH) % DEPTH;
      free = DEPTH - 1 - used;
      if (!en || free < MAXW + 1) begin
         if (m_drop < 255) m_drop++;
         return;
      end
      stored = (b.size() < 4 * MAXW) ? b.size() : 4 * MAXW;
      words  = (stored + 3) / 4;
      h      = m_wr;
      for (int w = 0; w < words; w++) begin
         e.data = '0;
         e.be   = '0;
         e.cyc  = 0;
         for (int k = 0; k < 4; k++) begin
            if (4 * w + k < stored) begin
               e.data[8*k +: 8] = b[4*w + k];
               e.be[k] = 1'b1;
            end
         end
         e.addr = 8'(BASE + (h + 1 + w) % DEPTH);
         exp_q.push_back(e);
      end
      e.addr = 8'(BASE + h);
      e.be   = 4'hF;
      e.data = {16'(stored), 8'(m_seq), 7'b0, 1'(b.size() > 4 * MAXW)};
      exp_q.push_back(e);
      m_wr  = (h + 1 + words) % DEPTH;
      m_seq = (m_seq + 1) % 256;
   endfunction

   task automatic do_frame(input string nm, input bytes_t b, input logic en, input int rd_off,
                           input bit perturb, input bit stray, output int adv, output int nwr);
      logic [6:0] rd;
      int wr0, irq0;
      rd = 7'(m_wr + rd_off);
      enable = en;
      sw_rd_ptr = rd;
      wr0 = int'(wr_ptr);
      irq0 = irq_cnt;
      log_q.delete();
      model_frame(b, en, rd);
      if (stray) send_byte(8'($urandom), 1'b0, 1'($urandom));
      foreach (b[i]) begin
         send_byte(b[i], i == 0, i == b.size() - 1);
         if (perturb) begin
            if (i == 0) begin
               enable = 1'($urandom);
               sw_rd_ptr = 7'($urandom);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
      end
      repeat (6) @(negedge clk);
      chk({nm, " nwrites"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s write%0d", nm, i),
             {20'b0, log_q[i].addr, log_q[i].be, log_q[i].data},
             {20'b0, exp_q[i].addr, exp_q[i].be, exp_q[i].data});
      chk({nm, " wr_ptr"}, 64'(wr_ptr), 64'(m_wr));
      chk({nm, " irq_pulses"}, 64'(irq_cnt - irq0), 64'(exp_q.size() != 0));
      chk({nm, " drop_count"}, 64'(drop_count), 64'(m_drop));
      adv = (int'(wr_ptr) - wr0 + DEPTH) % DEPTH;
      nwr = log_q.size();
   endtask

   initial begin
      vec_t   tbl[12];
      bytes_t b;
      int     adv, nwr, d, a;

      tbl[0]  = '{70, 1'b1, 0,   17, 17};
      tbl[1]  = '{1,  1'b1, 0,   2,  2};
      tbl[2]  = '{64, 1'b1, 0,   17, 17};
      tbl[3]  = '{65, 1'b1, 0,   17, 17};
      tbl[4]  = '{8,  1'b1, 10,  0,  0};
      tbl[5]  = '{8,  1'b1, 18,  3,  3};
      tbl[6]  = '{3,  1'b1, 17,  0,  0};
      tbl[7]  = '{6,  1'b0, 0,   0,  0};
      tbl[8]  = '{1,  1'b0, 0,   0,  0};
      tbl[9]  = '{7,  1'b1, 0,   3,  3};
      tbl[10] = '{63, 1'b1, 0,   17, 17};
      tbl[11] = '{2,  1'b1, 127, 2,  2};

      #2 reset_n = 1'b0;
      #1 chk("reset outputs", {rx_ready, wr_ptr, irq, drop_count, mem_address, mem_byteenable,
                               mem_chipselect, mem_write, mem_writedata, mem_clken}, 64'h1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Five-byte frame: full word, one-lane flush, header, then commit timing
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      do_frame("t1", b, 1'b1, 0, 1'b0, 1'b0, adv, nwr);
      if (log_q.size() == 3) begin
         chk("t1 data0", {log_q[0].addr, log_q[0].be, log_q[0].data}, {8'd129, 4'hF, 32'h04030201});
         chk("t1 data1", {log_q[1].addr, log_q[1].be, log_q[1].data}, {8'd130, 4'h1, 32'h00000005});
         chk("t1 header", {log_q[2].addr, log_q[2].be, log_q[2].data}, {8'd128, 4'hF, 32'h00050000});
         chk("t1 flush cycle", 64'(log_q[1].cyc), 64'(acc_cyc));
         chk("t1 header cycle", 64'(log_q[2].cyc), 64'(acc_cyc + 1));
         chk("t1 irq cycle", 64'(irq_cyc), 64'(acc_cyc + 2));
      end
      chk("t1 wr_ptr", 64'(wr_ptr), 64'd3);

      // Exactly one word: no flush write, seq advanced
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_frame("t2", b, 1'b1, 0, 1'b0, 1'b0, adv, nwr);
      if (log_q.size() == 2) begin
         chk("t2 data", {log_q[0].addr, log_q[0].be, log_q[0].data}, {8'd132, 4'hF, 32'hDDCCBBAA});
         chk("t2 header", {log_q[1].addr, log_q[1].be, log_q[1].data}, {8'd131, 4'hF, 32'h00040100});
      end
      chk("t2 nwrites", 64'(log_q.size()), 64'd2);

      for (int i = 0; i < 12; i++) begin
         do_frame($sformatf("vec%0d", i), rand_bytes(tbl[i].n), tbl[i].en, tbl[i].off,
                  1'b0, 1'b0, adv, nwr);
         chk($sformatf("vec%0d advance", i), 64'(adv), 64'(tbl[i].adv));
         chk($sformatf("vec%0d writes", i), 64'(nwr), 64'(tbl[i].nwr));
      end

      // No space: rx_ready stays high through the dropped frame
      enable = 1'b1;
      sw_rd_ptr = 7'(m_wr + 10);
      log_q.delete();
      send_byte(8'h11, 1'b1, 1'b0);
      chk("t4 ready in drop", 64'(rx_ready), 64'd1);
      send_byte(8'h22, 1'b0, 1'b0);
      chk("t4 ready in drop2", 64'(rx_ready), 64'd1);
      send_byte(8'h33, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      if (m_drop < 255) m_drop++;
      chk("t4 no writes", 64'(log_q.size()), 64'd0);
      chk("t4 drop_count", 64'(drop_count), 64'(m_drop));
      chk("t4 wr_ptr", 64'(wr_ptr), 64'(m_wr));

      // Walk the pointer to 126, then a 3-word frame wraps the ring
      d = (126 - m_wr + DEPTH) % DEPTH;
      while (d != 0) begin
         if (d > 17) a = (d - 17 >= 2) ? 17 : 15;
         else if (d >= 2) a = d;
         else a = 17;
         do_frame("pad", rand_bytes(4 * (a - 1)), 1'b1, 0, 1'b0, 1'b0, adv, nwr);
         d = (126 - m_wr + DEPTH) % DEPTH;
      end
      do_frame("t5", rand_bytes(12), 1'b1, 0, 1'b0, 1'b0, adv, nwr);
      if (log_q.size() == 4)
         chk("t5 addrs", {32'b0, log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[3].addr},
             {32'b0, 8'd255, 8'd128, 8'd129, 8'd254});
      chk("t5 wr_ptr", 64'(wr_ptr), 64'd2);

      for (int i = 0; i < 40; i++) begin
         do_frame($sformatf("rnd%0d", i), rand_bytes($urandom_range(1, 80)),
                  1'($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : 0,
                  1'b1, 1'($urandom_range(0, 4) == 0), adv, nwr);
      end

      // drop_count saturation with back-to-back single-byte frames
      enable = 1'b0;
      log_q.delete();
      for (int i = 0; i < 260; i++) begin
         send_byte(8'($urandom), 1'b1, 1'b1);
         if (m_drop < 255) m_drop++;
      end
      repeat (2) @(negedge clk);
      chk("sat drop_count", 64'(drop_count), 64'(m_drop));
      chk("sat no writes", 64'(log_q.size()), 64'd0);

      // Reset in the middle of a frame abandons it
      enable = 1'b1;
      sw_rd_ptr = 7'(m_wr);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 0, 1'b0);
      reset_n = 1'b0;
      #1 chk("t6 reset outputs", {rx_ready, wr_ptr, irq, drop_count, mem_address, mem_byteenable,
                                  mem_chipselect, mem_write, mem_writedata, mem_clken}, 64'h1);
      @(negedge clk);
      reset_n = 1'b1;
      m_wr = 0;
      m_seq = 0;
      m_drop = 0;
      do_frame("t6", rand_bytes(5), 1'b1, 0, 1'b0, 1'b0, adv, nwr);
      if (log_q.size() == 3)
         chk("t6 header addr", 64'(log_q[2].addr), 64'd128);

      chk("side signals", 64'(bad_side), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
